coe_sram_writer: RTL

- Loads distance-correction coefficient tables into external coefficient SRAM, one table per ping/pang channel, at base 18'h10000 (ping) or 18'h28000 (pang).
- The distance calculator reads these tables during scans; this block is the writer side of that table.
- Sits between the host parameter-download path (word stream with valid/ready) and the SRAM arbiter (request/grant).
- Writes are sequential from word 0 up to TABLE_WORDS-1, with status flags reported back to the host path.

---
 rtl/coe_sram_writer_pkg.sv | 26 ++
 rtl/coe_sram_writer.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/coe_sram_writer_pkg.sv
// Shared constants and state encoding for the coefficient table path.
// Used by both the SRAM writer and the distance-calculator reader.
package coe_sram_writer_pkg;

    localparam logic [17:0] SRAM_COE_BASE1 = 18'h10000;
    localparam logic [17:0] SRAM_COE_BASE2 = 18'h28000;
    localparam logic [17:0] TABLE_WORDS    = 18'h18000;

    localparam logic [3:0]  COE_NEG_NIBBLE = 4'hF;

    typedef enum logic [15:0] {
        S_IDLE      = 16'h0001,
        S_WAIT_DATA = 16'h0002,
        S_REQ       = 16'h0004,
        S_WRITE     = 16'h0008,
        S_NEXT      = 16'h0010,
        S_CHECK     = 16'h0020,
        S_DONE      = 16'h0040,
        S_ERR       = 16'h0080
    } coe_state_e;

    function automatic logic coe_is_neg(input logic [15:0] w);
        return w[15:12] == COE_NEG_NIBBLE;
    endfunction

endpackage

// File: rtl/coe_sram_writer.sv
// Writes a coefficient table word by word into SRAM via the arbiter.
// Define COE_LOAD_CHECKSUM_EN to require a trailer checksum word.
module coe_sram_writer #(
    parameter logic [17:0] TABLE_WORDS = coe_sram_writer_pkg::TABLE_WORDS
) (
    input  logic        i_clk_50m,
    input  logic        i_rst_n,
    input  logic        i_load_start,
    input  logic        i_table_sel,
    input  logic        i_load_abort,
    input  logic        i_coe_valid,
    input  logic [15:0] i_coe_data,
    output logic        o_coe_ready,
    output logic        o_sram_req,
    input  logic        i_sram_gnt,
    output logic [17:0] o_sram_addr,
    output logic [15:0] o_sram_wdata,
    output logic        o_sram_we,
    output logic        o_load_busy,
    output logic        o_load_done,
    output logic        o_load_err,
    output logic [17:0] o_word_cnt
);
    import coe_sram_writer_pkg::*;

    coe_state_e  state_q;
    coe_state_e  state_d;
    logic [17:0] base_q;
    logic [17:0] index_q;
    logic [17:0] word_cnt_q;
    logic [15:0] data_q;
    logic        abortable;

`ifdef COE_LOAD_CHECKSUM_EN
    logic [15:0] sum_q;
`endif

    assign o_word_cnt = word_cnt_q;

    assign abortable = (state_q == S_WAIT_DATA) || (state_q == S_REQ)
                    || (state_q == S_WRITE) || (state_q == S_NEXT)
                    || (state_q == S_CHECK);

    // State register.
    always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Base/index/count bookkeeping and accepted-word latch.
    always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            base_q     <= '0;
            index_q    <= '0;
            word_cnt_q <= '0;
            data_q     <= '0;
        end else begin
            if (state_q == S_IDLE && i_load_start) begin
                base_q     <= i_table_sel ? SRAM_COE_BASE2 : SRAM_COE_BASE1;
                index_q    <= '0;
                word_cnt_q <= '0;
            end
            if (state_q == S_WAIT_DATA && i_coe_valid) begin
                data_q <= i_coe_data;
            end
            if (state_q == S_NEXT) begin
                index_q    <= index_q + 18'd1;
                word_cnt_q <= word_cnt_q + 18'd1;
            end
            // a write completing under abort still counts as written
            if (state_q == S_WRITE && i_load_abort) begin
                word_cnt_q <= word_cnt_q + 18'd1;
            end
        end
    end

`ifdef COE_LOAD_CHECKSUM_EN
    // Running mod-2^16 sum of every word written to SRAM.
    always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sum_q <= '0;
        end else if (state_q == S_IDLE && i_load_start) begin
            sum_q <= '0;
        end else if (state_q == S_WRITE) begin
            sum_q <= sum_q + data_q;
        end
    end
`endif

    // Next-state and Moore outputs; abort overrides any active state.
    always_comb begin
        state_d      = state_q;
        o_coe_ready  = 1'b0;
        o_sram_req   = 1'b0;
        o_sram_we    = 1'b0;
        o_sram_addr  = '0;
        o_sram_wdata = '0;
        o_load_busy  = 1'b1;
        o_load_done  = 1'b0;
        o_load_err   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                o_load_busy = 1'b0;
                if (i_load_start) begin
                    state_d = S_WAIT_DATA;
                end
            end
            S_WAIT_DATA: begin
                o_coe_ready = 1'b1;
                if (i_coe_valid) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                o_sram_req = 1'b1;
                if (i_sram_gnt) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                o_sram_req   = 1'b1;
                o_sram_we    = 1'b1;
                o_sram_addr  = base_q + index_q;
                o_sram_wdata = data_q;
                state_d      = S_NEXT;
            end
            S_NEXT: begin
                if (index_q + 18'd1 == TABLE_WORDS) begin
                    state_d = S_CHECK;
                end else begin
                    state_d = S_WAIT_DATA;
                end
            end
            S_CHECK: begin
`ifdef COE_LOAD_CHECKSUM_EN
                o_coe_ready = 1'b1;
                if (i_coe_valid) begin
                    state_d = (i_coe_data == sum_q) ? S_DONE : S_ERR;
                end
`else
                state_d = S_DONE;
`endif
            end
            S_DONE: begin
                o_load_done = 1'b1;
                state_d     = S_IDLE;
            end
            S_ERR: begin
                o_load_err = 1'b1;
                state_d    = S_IDLE;
            end
            default: begin
                o_load_busy = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
        if (i_load_abort && abortable) begin
            state_d = S_ERR;
        end
    end

endmodule
